// File: rtl/nn_block_memory_banked.sv
// rtl/nn_block_memory_banked.sv - instruction store, banked data store and node-gather engine
// Gather reads one row across all data banks per beat and publishes the full vector atomically.
module nn_block_memory_banked #(
  parameter int DATA_W         = 16,
  parameter int INST_W         = 24,
  parameter int INST_DEPTH     = 1024,
  parameter int DATA_DEPTH     = 4096,
  parameter int NODE_LANES     = 16,
  parameter int WORDS_PER_BEAT = 4
) (
  input  logic                           iclk,
  input  logic                           irst_n,
  input  logic [$clog2(INST_DEPTH)-1:0]  iInstAddr,
  input  logic                           iInstWrite,
  input  logic [INST_W-1:0]              iInstWData,
  output logic [INST_W-1:0]              oInstr,
  input  logic [$clog2(DATA_DEPTH)-1:0]  iDataAddr,
  input  logic                           iDataRead,
  input  logic                           iDataWrite,
  input  logic [DATA_W-1:0]              iData,
  output logic                           oDataReady,
  output logic [DATA_W-1:0]              oData,
  output logic                           oDataValid,
  input  logic                           iNodeReq,
  input  logic [$clog2(DATA_DEPTH)-1:0]  iNodeAddr,
  output logic                           oNodeBusy,
  output logic [NODE_LANES*DATA_W-1:0]   oNodes,
  output logic                           oNodesValid
);

  localparam int DA_W  = $clog2(DATA_DEPTH);
  localparam int WPB   = WORDS_PER_BEAT;
  localparam int BK_W  = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int ROWS  = DATA_DEPTH / WPB;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BEATS = NODE_LANES / WPB;
  localparam int BT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NV_W  = NODE_LANES * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t             r_state;
  logic [ROW_W-1:0]   r_row;
  logic [BT_W-1:0]    r_beat;
  logic [NV_W-1:0]    r_shadow;

  logic [INST_W-1:0]  r_imem [INST_DEPTH];
  logic [DATA_W-1:0]  r_dmem [WPB][ROWS];

  logic [NV_W-1:0]    w_shadow_next;
  logic [DATA_W-1:0]  w_bank_rd [WPB];
  logic [ROW_W-1:0]   w_rd_row;
  logic [ROW_W-1:0]   w_data_row;
  logic [ROW_W-1:0]   w_node_row;
  logic [BK_W-1:0]    w_data_bank;
  logic               w_data_ready;
  logic               w_data_we;
  logic               w_data_re;
  logic               w_last_beat;

  assign w_data_bank  = BK_W'(iDataAddr % DA_W'(WPB));
  assign w_data_row   = ROW_W'(iDataAddr / DA_W'(WPB));
  assign w_node_row   = ROW_W'(iNodeAddr / DA_W'(WPB));
  assign w_data_ready = !oNodeBusy;
  assign w_data_we    = w_data_ready && iDataWrite;
  assign w_data_re    = w_data_ready && iDataRead && !iDataWrite;
  assign w_last_beat  = (r_beat == BT_W'(BEATS - 1));
  assign oDataReady   = w_data_ready;

  // The data port and the gather never read in the same cycle, so the banks share one row address.
  assign w_rd_row = (r_state == S_FETCH) ? r_row : w_data_row;

  always_comb begin
    for (int b = 0; b < WPB; b++) begin
      w_bank_rd[b] = r_dmem[b][w_rd_row];
    end
  end

  always_comb begin
    w_shadow_next = r_shadow;
    for (int b = 0; b < WPB; b++) begin
      w_shadow_next[(int'(r_beat) * WPB + b) * DATA_W +: DATA_W] = w_bank_rd[b];
    end
  end

  always_ff @(posedge iclk) begin
    if (iInstWrite) begin
      r_imem[iInstAddr] <= iInstWData;
    end
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      oInstr <= '0;
    end else begin
      oInstr <= r_imem[iInstAddr];
    end
  end

  always_ff @(posedge iclk) begin
    if (w_data_we) begin
      r_dmem[w_data_bank][w_data_row] <= iData;
    end
  end

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      oData      <= '0;
      oDataValid <= 1'b0;
    end else begin
      oDataValid <= w_data_re;
      if (w_data_re) begin
        oData <= w_bank_rd[w_data_bank];
      end
    end
  end

  // oNodes is only ever loaded with the completed vector on the final beat.
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_beat      <= '0;
      r_shadow    <= '0;
      oNodes      <= '0;
      oNodesValid <= 1'b0;
      oNodeBusy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          oNodesValid <= 1'b0;
          if (iNodeReq) begin
            r_row     <= w_node_row;
            r_beat    <= '0;
            oNodeBusy <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_shadow <= w_shadow_next;
          r_row    <= r_row + ROW_W'(1);
          if (w_last_beat) begin
            oNodes      <= w_shadow_next;
            oNodesValid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_beat <= r_beat + BT_W'(1);
          end
        end
        S_DONE: begin
          oNodesValid <= 1'b0;
          oNodeBusy   <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          oNodesValid <= 1'b0;
          oNodeBusy   <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
